// File: rtl/instr_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_pkg
// Description : Shared RV32I opcode constants, encoder format selects, the
//               request record and the legality / packing helper functions
//               used by instr_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_encoder_pkg;

    // Base opcodes accepted by the encoder
    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_TYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_B_TYPE = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

    // Encoder format selects
    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_SYS = 3'd6,
        FMT_BAD = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imme;
    } req_t;

    function automatic fmt_e fmt_of(input logic [6:0] op);
        case (op)
            OP_R_TYPE:                    fmt_of = FMT_R;
            OP_I_TYPE, OP_LOAD, OP_JALR:  fmt_of = FMT_I;
            OP_STORE:                     fmt_of = FMT_S;
            OP_B_TYPE:                    fmt_of = FMT_B;
            OP_LUI, OP_AUIPC:             fmt_of = FMT_U;
            OP_JAL:                       fmt_of = FMT_J;
            OP_SYSTEM:                    fmt_of = FMT_SYS;
            default:                      fmt_of = FMT_BAD;
        endcase
    endfunction

    // True when v is representable as a two's-complement value of 'bits' bits:
    // everything from bit (bits-1) upward must be a copy of the sign.
    function automatic logic sfits(input logic [31:0] v, input int bits);
        logic signed [31:0] t;
        t     = $signed(v) >>> (bits - 1);
        sfits = (t == '0) || (t == '1);
    endfunction

    function automatic logic is_shift(input req_t r);
        is_shift = (r.opcode == OP_I_TYPE) &&
                   ((r.funct3 == 3'b001) || (r.funct3 == 3'b101));
    endfunction

    function automatic logic is_legal(input req_t r);
        logic ok;
        ok = 1'b0;
        case (fmt_of(r.opcode))
            FMT_R, FMT_SYS: ok = 1'b1;
            FMT_I: begin
                if (is_shift(r)) ok = (r.imme[31:5] == '0);
                else             ok = sfits(r.imme, 12);
                if ((r.opcode == OP_LOAD) &&
                    ((r.funct3 == 3'b011) || (r.funct3 == 3'b110) || (r.funct3 == 3'b111)))
                    ok = 1'b0;
            end
            FMT_S: ok = sfits(r.imme, 12);
            FMT_B: ok = sfits(r.imme, 13) && !r.imme[0] &&
                        (r.funct3 != 3'b010) && (r.funct3 != 3'b011);
            FMT_U: ok = (r.imme[11:0] == '0);
            FMT_J: ok = sfits(r.imme, 21) && !r.imme[0];
            default: ok = 1'b0;
        endcase
        is_legal = ok;
    endfunction

    function automatic logic [31:0] encode(input req_t r);
        logic [11:0] imm_i;
        imm_i = r.imme[11:0];
        // Shift immediates carry the SRA/SRL select in the upper imm bits
        if (is_shift(r)) imm_i[11:5] = {1'b0, r.funct7, 5'b0};
        case (fmt_of(r.opcode))
            FMT_R:   encode = {1'b0, r.funct7, 5'b0, r.rs2, r.rs1, r.funct3, r.rd, r.opcode};
            FMT_I:   encode = {imm_i, r.rs1, r.funct3, r.rd, r.opcode};
            FMT_S:   encode = {r.imme[11:5], r.rs2, r.rs1, r.funct3, r.imme[4:0], r.opcode};
            FMT_B:   encode = {r.imme[12], r.imme[10:5], r.rs2, r.rs1, r.funct3,
                               r.imme[4:1], r.imme[11], r.opcode};
            FMT_U:   encode = {r.imme[31:12], r.rd, r.opcode};
            FMT_J:   encode = {r.imme[20], r.imme[10:1], r.imme[11], r.imme[19:12],
                               r.rd, r.opcode};
            FMT_SYS: encode = EBREAK_WORD;
            default: encode = '0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : instr_fifo
// Description : Synchronous FIFO, DEPTH words of WIDTH bits. rd_data shows the
//               head word and reads as zero while empty.
// Ports       : clk, rst (async, active high), wr_en/wr_data push,
//               rd_en/rd_data pop, count/full/empty status.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             w_wr, w_rd;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    assign w_rd = rd_en & ~empty;
    assign w_wr = wr_en & (~full | w_rd);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointers wrap by natural overflow
        if (w_wr) wr_ptr_d = wr_ptr_q + AW'(1);
        if (w_rd) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({w_wr, w_rd})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: empty gates the read side
    always_ff @(posedge clk) begin
        if (w_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : RV32I field-level request encoder. S1 registers an accepted
//               request; S2 checks legality, packs the word and pushes it to
//               the output FIFO or drops it with an error pulse.
// Ports       : clk, rst (async, active high); in_* request handshake and
//               fields; out_valid/out_ready/out_instr FIFO head;
//               err_pulse / err_cnt drop reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic        in_funct7,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_imme,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        err_pulse,
    output logic [7:0]  err_cnt
);
    localparam int CW = $clog2(DEPTH) + 1;

    req_t          s1_req_q, s1_req_d;
    logic          s1_valid_q, s1_valid_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;
    logic          w_accept, w_legal, w_push, w_drop;
    logic [31:0]   w_word;
    logic [CW-1:0] w_occupancy;

    // Reserve a slot for the word sitting in S1 so S2 can always push; uses
    // registered state only, so a pop frees space one cycle later.
    assign w_occupancy = fifo_count + CW'(s1_valid_q);
    assign in_ready    = ~fifo_full & (w_occupancy < CW'(DEPTH));
    assign w_accept    = in_valid & in_ready;

    assign w_legal   = is_legal(s1_req_q);
    assign w_word    = encode(s1_req_q);
    assign w_push    = s1_valid_q & w_legal;
    assign w_drop    = s1_valid_q & ~w_legal;
    assign err_pulse = w_drop;
    assign err_cnt   = err_cnt_q;
    assign out_valid = ~fifo_empty;

    always_comb begin
        s1_valid_d = w_accept;
        s1_req_d   = s1_req_q;
        if (w_accept) begin
            s1_req_d.opcode = in_opcode;
            s1_req_d.funct3 = in_funct3;
            s1_req_d.funct7 = in_funct7;
            s1_req_d.rs1    = in_rs1;
            s1_req_d.rs2    = in_rs2;
            s1_req_d.rd     = in_rd;
            s1_req_d.imme   = in_imme;
        end
        err_cnt_d = err_cnt_q;
        if (w_drop && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_req_q   <= '0;
            err_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_req_q   <= s1_req_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_push),
        .wr_data (w_word),
        .rd_en   (out_ready),
        .rd_data (out_instr),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Directed self-checking bench for instr_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUI = 7'b0010111;
    localparam logic [6:0] OP_SYS = 7'b1110011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic        in_funct7;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic [31:0] in_imme;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        err_pulse;
    logic [7:0]  err_cnt;

    int passed = 0;
    int total  = 0;

    instr_encoder #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_rd     (in_rd),
        .in_imme   (in_imme),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Present a request and hold it until the edge that accepts it.
    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [31:0] imm);
        int n;
        n = 0;
        in_opcode = op; in_funct3 = f3; in_funct7 = f7;
        in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_imme = imm;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) chk("send_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Wait for the head word, check it, then pop it with a one-cycle ready.
    task automatic pop_expect(input string tag, input logic [31:0] exp);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk(tag, out_instr, exp);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_opcode = '0; in_funct3 = '0; in_funct7 = 1'b0;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imme = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr,      32'd0);
        chk("rst_err_pulse", 32'(err_pulse), 32'd0);
        chk("rst_err_cnt",   32'(err_cnt),   32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // addi x1,x0,5: not visible one edge after acceptance, visible after two
        send(OP_I, 3'b000, 1'b0, 5'd0, 5'd0, 5'd1, 32'd5);
        chk("addi_lat1_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("addi_lat2_valid", 32'(out_valid), 32'd1);
        pop_expect("addi", 32'h0050_0093);
        chk("addi_drained", 32'(out_valid), 32'd0);

        // Batch of legal encodings
        send(OP_R,   3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 32'd0);           // sub x3,x1,x2
        send(OP_B,   3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFC);   // beq x1,x2,-4
        send(OP_JAL, 3'b000, 1'b0, 5'd0, 5'd0, 5'd1, 32'd2048);        // jal x1,+2048
        send(OP_LUI, 3'b000, 1'b0, 5'd0, 5'd0, 5'd5, 32'h1234_5000);   // lui x5,0x12345
        pop_expect("sub",  32'h4020_81B3);
        pop_expect("beq",  32'hFE20_8EE3);
        pop_expect("jal",  32'h0010_00EF);
        pop_expect("lui",  32'h1234_52B7);

        send(OP_ST,  3'b010, 1'b0, 5'd1, 5'd2, 5'd0, 32'd8);           // sw x2,8(x1)
        send(OP_I,   3'b101, 1'b1, 5'd6, 5'd0, 5'd5, 32'd3);           // srai x5,x6,3
        send(OP_LD,  3'b010, 1'b0, 5'd1, 5'd0, 5'd5, 32'd4);           // lw x5,4(x1)
        send(OP_AUI, 3'b000, 1'b0, 5'd0, 5'd0, 5'd7, 32'h0000_1000);   // auipc x7,1
        pop_expect("sw",    32'h0020_A423);
        pop_expect("srai",  32'h4033_5293);
        pop_expect("lw",    32'h0040_A283);
        pop_expect("auipc", 32'h0000_1397);

        // Misaligned branch is dropped, the following addi is not
        send(OP_B, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 32'd3);
        chk("bad_b_pulse", 32'(err_pulse), 32'd1);
        chk("bad_b_cnt0",  32'(err_cnt),   32'd0);
        send(OP_I, 3'b000, 1'b0, 5'd0, 5'd0, 5'd1, 32'd5);
        chk("bad_b_pulse_end", 32'(err_pulse), 32'd0);
        chk("bad_b_cnt1",      32'(err_cnt),   32'd1);
        pop_expect("after_bad_b", 32'h0050_0093);
        chk("after_bad_b_empty", 32'(out_valid), 32'd0);

        // srli with shamt 32 is out of range
        send(OP_I, 3'b101, 1'b0, 5'd1, 5'd0, 5'd2, 32'd32);
        chk("srli32_pulse", 32'(err_pulse), 32'd1);
        @(posedge clk); #1;
        chk("srli32_cnt",   32'(err_cnt),   32'd2);
        chk("srli32_empty", 32'(out_valid), 32'd0);

        // load with funct3 011 is illegal
        send(OP_LD, 3'b011, 1'b0, 5'd1, 5'd0, 5'd2, 32'd0);
        chk("ld011_pulse", 32'(err_pulse), 32'd1);
        @(posedge clk); #1;
        chk("ld011_cnt", 32'(err_cnt), 32'd3);

        // Backpressure: four accepted, fifth stalls
        for (int i = 1; i <= 4; i++)
            send(OP_I, 3'b000, 1'b0, 5'd0, 5'd0, 5'(i), 32'(i));
        chk("bp_ready_low", 32'(in_ready), 32'd0);
        in_opcode = OP_I; in_funct3 = 3'b000; in_rd = 5'd5; in_imme = 32'd5;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("bp_ready_held", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        pop_expect("bp_w1", (32'd1 << 20) | (32'd1 << 7) | 32'h13);
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        for (int i = 2; i <= 4; i++)
            pop_expect("bp_w", (32'(i) << 20) | (32'(i) << 7) | 32'h13);
        chk("bp_drained", 32'(out_valid), 32'd0);
        for (int i = 5; i <= 6; i++)
            send(OP_I, 3'b000, 1'b0, 5'd0, 5'd0, 5'(i), 32'(i));
        for (int i = 5; i <= 6; i++)
            pop_expect("bp_tail", (32'(i) << 20) | (32'(i) << 7) | 32'h13);

        // Saturation of the error counter
        for (int i = 0; i < 260; i++)
            send(OP_BAD, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        @(posedge clk); #1;
        chk("err_sat",       32'(err_cnt),   32'd255);
        chk("err_sat_empty", 32'(out_valid), 32'd0);

        // Asynchronous reset with three words queued and S1 occupied
        for (int i = 1; i <= 4; i++)
            send(OP_I, 3'b000, 1'b0, 5'd0, 5'd0, 5'(i), 32'(i));
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_ready", 32'(in_ready),  32'd0);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready),  32'd1);
        chk("mid_rst_instr", out_instr,      32'd0);
        chk("mid_rst_cnt",   32'(err_cnt),   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        send(OP_SYS, 3'b111, 1'b1, 5'd3, 5'd4, 5'd9, 32'h0000_DEAD);
        pop_expect("ebreak", 32'h0010_0073);
        chk("final_empty", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
# instr_encoder

RV32I instruction encoder: the inverse of the pipeline's instruction decoder. It accepts field-level requests (opcode, funct3, funct7 bit, Rs1/Rs2/Rd, 32-bit immediate), checks them for legality, packs them into a 32-bit instruction word, and buffers results in an output FIFO. It sits between the debug/self-test program generator and the instruction-injection port of the fetch stage, under valid/ready handshakes on both sides.

## Interface
- `DEPTH`, 4: output FIFO depth in words; power of two, ≥2.
- `clk` input 1: single clock; all state changes on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: request present.
- `in_ready` output 1: request accepted on the edge where `in_valid & in_ready`.
- `in_opcode` input 7: one of the `define.v` opcodes: R_type, I_type, load, store, B_type, jal, jalr, lui, auipc, or SYSTEM 7'b1110011.
- `in_funct3` input 3: funct3 field.
- `in_funct7` input 1: instr[30] (SUB/SRA select).
- `in_rs1`, `in_rs2`, `in_rd` input 5 each: register fields.
- `in_imme` input 32: immediate as a signed byte value; for U-type, the full 32-bit value.
- `out_valid` output 1: FIFO non-empty.
- `out_ready` input 1: consumer pops on `out_valid & out_ready`.
- `out_instr` output 32: FIFO head word.
- `err_pulse` output 1: one-cycle pulse when a request is dropped as illegal.
- `err_cnt` output 8: saturating count of dropped requests.

## Operation
- Stage S1: an accepted request is registered with `s1_valid`. Stage S2 combinationally encodes the S1 register and writes it to the FIFO on the next edge.
- Encoding by opcode:
  - R_type: {1'b0, funct7, 5'b0, rs2, rs1, f3, rd, op}.
  - I_type, load, jalr: {imme[11:0], rs1, f3, rd, op}.
  - I_type with funct3 001 or 101: imm[11:5] is forced to {1'b0, funct7, 5'b0}.
  - store: {imme[11:5], rs2, rs1, f3, imme[4:0], op}.
  - B_type: {imme[12], imme[10:5], rs2, rs1, f3, imme[4:1], imme[11], op}.
  - lui, auipc: {imme[31:12], rd, op}.
  - jal: {imme[20], imme[10:1], imme[11], imme[19:12], rd, op}.
  - SYSTEM: always 32'h00100073 (ebreak). All other fields are ignored.
- Legality rules. Any violation drops the request: no FIFO write, `err_pulse` is high for the S2 cycle, and `err_cnt` increments and saturates at 255.
  - I, load, jalr, store: imme must sign-fit in 12 bits.
  - Shift immediates: imme must be in 0..31.
  - B: must sign-fit in 13 bits, with imme[0]=0.
  - jal: must sign-fit in 21 bits, with imme[0]=0.
  - U: imme[11:0] must be 0.
  - B and load: funct3 must not be 010 or 011 (B) or 011, 110, 111 (load).
  - Any opcode not listed above is illegal.
- Flow control: `in_ready = (fifo_count + s1_valid) < DEPTH`, computed from registered state only, with no same-cycle pop bypass. The FIFO can therefore never overflow.
- The FIFO preserves request order. Dropped requests leave no gap.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_instr`=0, `err_pulse`=0, `err_cnt`=0, `s1_valid`=0, FIFO empty.
- Latency: a request accepted at edge k is written at edge k+1. With an empty FIFO, `out_valid` is high after edge k+1, so minimum request-to-output latency is 2 edges.
- Throughput: one word per cycle when `out_ready` is held high.
- Simultaneous push and pop on a full FIFO: both take effect and the count is unchanged. Because `in_ready` does not bypass the pop, `in_ready` rises one cycle after space frees.
- `err_pulse` aligns with the S2 cycle of the offending request.
- `rst` asserted mid-stream: S1 and FIFO contents are discarded immediately and asynchronously. Outputs return to their reset values, and `err_cnt` is cleared.

## Structure
- Opcode constants come from `define.v`. Add a SYSTEM opcode and an EBREAK word constant there.
- Encoder format-select constants (R/I/S/B/U/J/SYS) belong in the same shared header.
- Sub-module `instr_fifo`: synchronous FIFO with parameterised `DEPTH` and width 32, exposing `count`, `full`, `empty`. The encoder and legality checker stay in `instr_encoder`.

## Test plan
- addi x1,x0,5 (I_type, f3=000, imme=5) → `out_instr`=32'h00500093 two edges after acceptance.
- sub x3,x1,x2 (R_type, funct7=1) → 32'h402081B3; beq x1,x2,-4 → 32'hFE208EE3; jal x1,+2048 → 32'h001000EF.
- B_type with imme=3, then addi → `err_pulse` for one cycle, `err_cnt`=1, and only 32'h00500093 is output. Also check a srli with imme=32 is dropped.
- Hold `out_ready`=0 and offer 6 requests → `in_ready` falls after 4 acceptances (DEPTH=4). Release `out_ready` → 4 words drain in order, then the remaining 2 follow.
- Push 256+ illegal requests → `err_cnt` saturates at 255.
- Assert `rst` with 3 words queued and S1 full → `out_valid`=0 and `in_ready`=1 immediately. After release, a fresh ebreak request yields 32'h00100073.
